// File: rtl/uart_tx_fifo_reader.sv
// UART transmit engine that pops words from a standard-mode synchronous FIFO
// (read latency 1, data_valid flag) and sends each as start bit, DATA_BITS
// LSB-first, optional parity and STOP_BITS stop bits on a registered TX line.
//
// Handshake: fifo_rd_en is a single-cycle pop request, raised only in IDLE,
// only when fifo_empty is low, tx_enable is high and no frame_done pulse is
// being emitted. The FIFO answers with fifo_data_valid/fifo_dout exactly one
// cycle later; the WAIT state consumes that response or flags rd_miss when
// it is absent. There is no back-pressure on the FIFO side.
module uart_tx_fifo_reader #(
    parameter int    CLKS_PER_BIT = 868,
    parameter int    DATA_BITS    = 8,
    parameter string PARITY       = "none",
    parameter int    STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_enable,
    input  logic [DATA_BITS-1:0] fifo_dout,
    input  logic                 fifo_empty,
    input  logic                 fifo_data_valid,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 rd_miss,
    output logic [2:0]           state_dbg
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam bit PAR_EN  = (PARITY != "none");
    localparam bit PAR_ODD = (PARITY == "odd");

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t                state;
    logic [BAUD_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0]  shift_reg;
    logic                  parity_bit;
    logic                  baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // The pop must see the FIFO flag of the current cycle, so it is decoded
    // from the registered state; the frame_done cycle is kept as idle line.
    assign fifo_rd_en = (state == S_IDLE) && !frame_done && tx_enable &&
                        !fifo_empty && !reset;

    // Busy covers the pop cycle and every non-idle state.
    assign busy = fifo_rd_en || (state != S_IDLE);

    assign state_dbg = state;

    // Frame sequencer: state, bit/baud counters, shift register and TX line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            rd_miss    <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo_rd_en) begin
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (fifo_data_valid) begin
                        shift_reg  <= fifo_dout;
                        parity_bit <= (^fifo_dout) ^ PAR_ODD;
                        tx         <= 1'b0;
                        state      <= S_START;
                    end else begin
                        rd_miss <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shift_reg[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PAR_EN) begin
                                tx    <= parity_bit;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx      <= shift_reg[1];
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_PARITY: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                S_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt    <= '0;
                            frame_done <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end

                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo_reader.md
# uart_tx_fifo_reader

UART transmit engine that drains a synchronous FIFO and serializes each word as an asynchronous frame on a single TX line. It is the read-side consumer of the TX `sync_fifo`, a standard-mode FIFO with read latency 1 and a `data_valid` flag. Host logic writes bytes into the FIFO and this block pops and transmits them LSB-first. Format: start bit, DATA_BITS, optional parity, STOP_BITS.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5..9. Equals the FIFO width.
- `PARITY`, "none": "none", "even" or "odd".
- `STOP_BITS`, 1: 1 or 2.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tx_enable`  in  1  when high, new frames may start. When low, an in-progress frame completes and no further pop is issued.
- `fifo_dout`  in  DATA_BITS  FIFO read data, valid when `fifo_data_valid` is high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data_valid`  in  1  FIFO read-data-valid flag, one cycle after an accepted `rd_en`.
- `fifo_rd_en`  out  1  single-cycle pop request.
- `tx`  out  1  serial output, idle high, registered.
- `busy`  out  1  high from pop request until the last stop-bit cycle ends.
- `frame_done`  out  1  one-cycle pulse in the cycle after the final stop-bit cycle.
- `rd_miss`  out  1  sticky flag; sets if `fifo_data_valid` is absent in the WAIT state. Cleared only by reset.

## Operation
- States: IDLE, WAIT, START, DATA, PARITY, STOP.
- **IDLE:**
  - `tx`=1.
  - If `tx_enable && !fifo_empty`: drive `fifo_rd_en`=1 for exactly this cycle and go to WAIT.
- **WAIT:**
  - If `fifo_data_valid`: load a shift register with `fifo_dout` and compute parity (XOR of data bits; inverted for "odd"). Go to START.
  - Otherwise: set `rd_miss` and return to IDLE.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- **DATA:**
  - Output shift-register bit 0 for CLKS_PER_BIT cycles, then shift right.
  - After DATA_BITS bits, go to PARITY, or to STOP if PARITY="none".
- **PARITY:** `tx`=parity bit for CLKS_PER_BIT cycles.
- **STOP:**
  - `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - Then return to IDLE and pulse `frame_done`.
- **Counters:**
  - Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
  - Bit counter: width $clog2(DATA_BITS+1).
  - Both counters clear on every state entry.
- `tx_enable` is sampled only in IDLE. Deasserting it mid-frame has no effect on the current frame.
- `fifo_rd_en` is never asserted outside IDLE, and never asserted while `fifo_empty`=1.
- **Reset values:** state=IDLE, `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, `rd_miss`=0, counters=0.
- **Reset mid-frame:** `tx` returns high on the next edge and the popped word is discarded. No partial frame resumes.

## Timing
- Pop to line: `fifo_rd_en` in cycle N, capture in N+1, `tx` falls at the N+2 edge.
- Frame length: (1 + DATA_BITS + P + STOP_BITS)×CLKS_PER_BIT cycles, where P=1 if parity is enabled, else 0.
- Back-to-back: with the FIFO non-empty, the next frame's start bit begins 3 cycles after the stop bit ends. These are the `frame_done`/IDLE cycle, the WAIT cycle, and the `tx` register update, all with `tx` high (extra idle; legal UART).
- `busy` rises with `fifo_rd_en` and falls in the `frame_done` cycle.
- `tx` is glitch-free: it changes only at bit boundaries.

## Test plan
- **Single byte, 8N1:**
  - Setup: CLKS_PER_BIT=4; FIFO holds 0xA5.
  - Required: one `fifo_rd_en` pulse, then `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total).
  - Required: `frame_done` 1 cycle later; `busy` low afterwards.
- **Even parity:**
  - Setup: PARITY="even"; byte 0x07.
  - Required: parity bit 1, frame 11 bits. With "odd" the parity bit is 0.
- **Burst of 3 bytes:**
  - Stimulus: 0x00, 0xFF, 0x55 queued.
  - Required: exactly 3 pops, frames in FIFO order, a 3-cycle high gap between stop bit and next start bit, `fifo_rd_en` low once `fifo_empty` asserts.
- **`tx_enable` low mid-frame:**
  - Stimulus: `tx_enable` goes low while 2 bytes remain queued.
  - Required: the current frame completes intact and no further `fifo_rd_en` is issued until `tx_enable`=1.
- **Reset mid-DATA:**
  - Stimulus: assert `reset` at bit 3 of a frame.
  - Required: `tx`=1, `busy`=0 and `rd_miss`=0 on the next edge; the next queued byte transmits cleanly after reset release.
- **Missing `data_valid`:**
  - Stimulus: suppress `fifo_data_valid` after a pop.
  - Required: `rd_miss`=1 (sticky), `tx` stays high, and the block returns to IDLE and serves the next byte normally.
